bnn_layer_engine: RTL and testbench
===================================

// Module: bnn_layer_engine
// PURPOSE
//  Parametrised binary layer core: XNOR-popcount of each input activation vector against every
//  output neuron's weight vector, then BN-threshold to one output bit, packed and written to the next
//  layer's buffer. Sits between a previous-layer ping-pong activation SRAM pair and a next-layer pair.
//  Weight/threshold SRAMs are external. Successor to the fixed second-layer datapath, adding generic
//  widths/depths, a per-neuron sign-flip threshold and explicit bank handshakes.
// PARAMETERS
//  ACT_W     64   bits per activation/weight word
//  IN_WORDS  16   words per input vector (fan-in = ACT_W*IN_WORDS)
//  OUT_CH    128  output neurons; multiple of OUT_W
//  OUT_W     64   output word width (packed result bits)
//  NPIX      8    input vectors (pixels) per frame
//  CNT_W     $clog2(ACT_W*IN_WORDS+1)  popcount/threshold width (derived, localparam)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous reset, active-high
//  layer_en   in   1      1 = may start new frames; 0 = finish current frame, then hold IDLE
//  pre_full   in   2      level: previous-layer bank b holds a complete frame
//  pre_empty  out  2      1-cycle pulse: bank b fully consumed, released to producer
//  pre_en     out  1      activation read strobe
//  pre_bank   out  1      bank being read
//  pre_addr   out  $clog2(NPIX*IN_WORDS)  word address = pix*IN_WORDS + w
//  pre_data   in   ACT_W  read data, valid the cycle after pre_en
//  wt_en      out  1      weight read strobe (same cycle as pre_en)
//  wt_addr    out  $clog2(OUT_CH*IN_WORDS)  = o*IN_WORDS + w
//  wt_data    in   ACT_W  weight data, valid the cycle after wt_en
//  th_en      out  1      threshold read strobe, asserted at w==0 of each neuron
//  th_addr    out  $clog2(OUT_CH)  = o
//  th_data    in   CNT_W+1  {flip, threshold}, valid the cycle after th_en
//  nxt_empty  in   2      level: next-layer bank b free for writing
//  nxt_full   out  2      1-cycle pulse: bank b written with a complete frame
//  nxt_we     out  1      write strobe
//  nxt_bank   out  1      bank being written
//  nxt_addr   out  $clog2(NPIX*OUT_CH/OUT_W)  = pix*(OUT_CH/OUT_W) + o/OUT_W
//  nxt_data   out  OUT_W  packed bits; bit (o mod OUT_W) = neuron o
//  busy       out  1      high in RUN/DRAIN
// BEHAVIOUR
//  Reset: FSM=IDLE, in/out bank pointers=0, all counters/accumulators 0, every output 0; no pulses.
//  FSM: IDLE -> RUN when layer_en & pre_full[ib] & nxt_empty[ob]; RUN -> DRAIN after last read issued;
//   DRAIN -> DONE once last write done; DONE (1 cycle): pulse pre_empty[ib], nxt_full[ob],
//   toggle ib and ob, -> IDLE. Frame start checks only in IDLE; handshake inputs ignored mid-frame.
//  RUN issue order: pix outer, o middle, w inner; one pre/wt read per cycle, no bubbles between
//   neurons or pixels; activation words are re-fetched per neuron. Issue cycles = NPIX*OUT_CH*IN_WORDS.
//  Datapath (1-cycle read latency): acc = (w==0 ? 0 : acc) + popcount(~(pre_data ^ wt_data)).
//   On the last word's data cycle: pop = acc_prev + popcount(last); bit = flip ? (pop < th) : (pop >= th);
//   unsigned CNT_W compare. bit shifts into pack reg at position o mod OUT_W.
//  Write: nxt_we pulses the cycle after bit OUT_W-1 of a word is formed; OUT_W/OUT_W-aligned.
//  Latency: last write 2 cycles after last read issued; DONE the following cycle.
//  layer_en dropped mid-frame: frame completes normally, no new frame starts.
//  pre_full/nxt_empty both ready for the next bank in the DONE cycle: next frame starts the cycle
//   after IDLE is entered (1 idle cycle between frames).
//  rst mid-frame: abort immediately, return to reset state; no pre_empty/nxt_full pulse; partial writes
//   to next bank are left as-is (producer/consumer reset in the same cycle).
//  Addresses/counters wrap to 0 at frame end; never exceed listed ranges.
// TESTING (ACT_W=8, IN_WORDS=2, OUT_CH=8, OUT_W=8, NPIX=2 unless noted)
//  1 All pre/wt words 8'hFF, th={0,16} -> pop=16 each; nxt_data 8'hFF at addr 0,1; nxt_full=2'b01
//    pulse, pre_empty=2'b01 pulse; 32 read cycles; busy low after.
//  2 wt for o=3 = 8'h00, th={0,9}: bit3=0 (pop 0); same with th={1,9}: bit3=1; pop==th=16 flip=0 -> 1.
//  3 Ping-pong: pre_full=2'b11, nxt_empty=2'b11 -> frame on bank0 then bank1, pre_bank/nxt_bank toggle,
//    exactly one idle cycle between frames.
//  4 nxt_empty[0]=0 with pre_full[0]=1 -> stays IDLE, no strobes; raise nxt_empty[0] -> starts next cycle.
//  5 rst asserted at read cycle 10 -> next cycle all outputs 0, no full/empty pulses; restart on bank0.
//  6 layer_en=0 at read cycle 5 -> frame completes, nxt_full pulses, no second frame despite ready banks.

Source files
------------

// File: rtl/bnn_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module   : bnn_layer_engine
//  Purpose  : Binary neural network layer core. Each input activation vector
//             (one pixel) is XNOR-popcounted against the weight vector of
//             every output neuron. The count is compared with a per-neuron
//             threshold, which may be sign-flipped, to give one output bit.
//             The bits are packed into OUT_W-wide words and written to the
//             next layer's ping-pong buffer.
//  Ports    : clk, rst                   clock, synchronous active-high reset
//             layer_en                   allow new frames to start
//             pre_full / pre_empty       previous-layer bank handshake
//             pre_en/bank/addr/data      activation SRAM read port
//             wt_en/addr/data            weight SRAM read port
//             th_en/addr/data            {flip, threshold} SRAM read port
//             nxt_empty / nxt_full       next-layer bank handshake
//             nxt_we/bank/addr/data      next-layer write port
//             busy                       frame in flight (RUN or DRAIN)
//  Revision : 1.0  initial release
// ============================================================================
module bnn_layer_engine #(
   parameter int ACT_W    = 64,
   parameter int IN_WORDS = 16,
   parameter int OUT_CH   = 128,
   parameter int OUT_W    = 64,
   parameter int NPIX     = 8,
   localparam int CNT_W   = $clog2(ACT_W*IN_WORDS+1),
   localparam int PRE_AW  = (NPIX*IN_WORDS > 1) ? $clog2(NPIX*IN_WORDS) : 1,
   localparam int WT_AW   = (OUT_CH*IN_WORDS > 1) ? $clog2(OUT_CH*IN_WORDS) : 1,
   localparam int TH_AW   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
   localparam int NXT_AW  = (NPIX*OUT_CH/OUT_W > 1) ? $clog2(NPIX*OUT_CH/OUT_W) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              layer_en,
   // previous-layer activation buffer
   input  logic [1:0]        pre_full,
   output logic [1:0]        pre_empty,
   output logic              pre_en,
   output logic              pre_bank,
   output logic [PRE_AW-1:0] pre_addr,
   input  logic [ACT_W-1:0]  pre_data,
   // weight and threshold memories
   output logic              wt_en,
   output logic [WT_AW-1:0]  wt_addr,
   input  logic [ACT_W-1:0]  wt_data,
   output logic              th_en,
   output logic [TH_AW-1:0]  th_addr,
   input  logic [CNT_W:0]    th_data,
   // next-layer activation buffer
   input  logic [1:0]        nxt_empty,
   output logic [1:0]        nxt_full,
   output logic              nxt_we,
   output logic              nxt_bank,
   output logic [NXT_AW-1:0] nxt_addr,
   output logic [OUT_W-1:0]  nxt_data,
   output logic              busy
);

   // counter widths (at least one bit so degenerate sizes still elaborate)
   localparam int PIX_W = (NPIX > 1)     ? $clog2(NPIX)     : 1;
   localparam int O_W   = (OUT_CH > 1)   ? $clog2(OUT_CH)   : 1;
   localparam int WD_W  = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
   localparam int PK_W  = (OUT_W > 1)    ? $clog2(OUT_W)    : 1;
   localparam int WPP   = OUT_CH / OUT_W;   // packed output words per pixel

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   // bank pointers
   logic ib, ob;

   // issue counters: pixel outer, neuron middle, word inner
   logic [PIX_W-1:0] pix;
   logic [O_W-1:0]   och;
   logic [WD_W-1:0]  wrd;

   logic w_last, o_last, p_last, issue_last, start;

   // read-data stage (one cycle behind issue)
   logic             vld_d1, first_d1, last_d1, flast_d1;
   logic [O_W-1:0]   och_d1;
   logic [PIX_W-1:0] pix_d1;

   // accumulation and threshold
   logic [CNT_W-1:0] acc;
   logic [CNT_W:0]   th_reg;
   logic [ACT_W-1:0] xnor_word;
   logic [CNT_W-1:0] word_pop, acc_base, pop_sum, thr;
   logic [CNT_W:0]   th_cur;
   logic             flip, bit_val;

   // output packing / write port
   logic [OUT_W-1:0]  pack;
   logic [PK_W-1:0]   bpos;
   logic [NXT_AW-1:0] word_idx;
   logic              we_r, last_wr_r;
   logic [NXT_AW-1:0] nxt_addr_r;

   assign w_last     = (wrd == WD_W'(IN_WORDS-1));
   assign o_last     = (och == O_W'(OUT_CH-1));
   assign p_last     = (pix == PIX_W'(NPIX-1));
   assign issue_last = (state == S_RUN) && w_last && o_last && p_last;
   assign start      = layer_en && pre_full[ib] && nxt_empty[ob];

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pre_en    = 1'b0;
      wt_en     = 1'b0;
      th_en     = 1'b0;
      busy      = 1'b0;
      pre_empty = 2'b00;
      nxt_full  = 2'b00;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            pre_en = 1'b1;
            wt_en  = 1'b1;
            th_en  = (wrd == '0);
            busy   = 1'b1;
            if (issue_last) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            // the final word of the frame is being written this cycle
            if (we_r && last_wr_r) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            pre_empty = ib ? 2'b10 : 2'b01;
            nxt_full  = ob ? 2'b10 : 2'b01;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // bank pointers advance once per completed frame
   always_ff @(posedge clk) begin
      if (rst) begin
         ib <= 1'b0;
         ob <= 1'b0;
      end else if (state == S_DONE) begin
         ib <= ~ib;
         ob <= ~ob;
      end
   end

   // ------------------------------------------------------------------
   // Issue counters; they naturally wrap to 0 on the last issue
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wrd <= '0;
         och <= '0;
         pix <= '0;
      end else if (state == S_RUN) begin
         wrd <= w_last ? '0 : wrd + WD_W'(1);
         if (w_last) begin
            och <= o_last ? '0 : och + O_W'(1);
            if (o_last) begin
               pix <= p_last ? '0 : pix + PIX_W'(1);
            end
         end
      end
   end

   assign pre_bank = ib;
   assign nxt_bank = ob;
   assign pre_addr = PRE_AW'(32'(pix) * IN_WORDS + 32'(wrd));
   assign wt_addr  = WT_AW'(32'(och) * IN_WORDS + 32'(wrd));
   assign th_addr  = TH_AW'(och);

   // ------------------------------------------------------------------
   // Datapath on the read-data cycle
   // ------------------------------------------------------------------
   assign xnor_word = ~(pre_data ^ wt_data);

   always_comb begin
      word_pop = '0;
      for (int i = 0; i < ACT_W; i++) begin
         word_pop = word_pop + CNT_W'(xnor_word[i]);
      end
   end

   // On the first word the threshold comes straight from the SRAM; later
   // words use the copy captured on that first data cycle.
   assign acc_base = first_d1 ? '0 : acc;
   assign pop_sum  = acc_base + word_pop;
   assign th_cur   = first_d1 ? th_data : th_reg;
   assign flip     = th_cur[CNT_W];
   assign thr      = th_cur[CNT_W-1:0];
   assign bit_val  = flip ? (pop_sum < thr) : (pop_sum >= thr);

   assign bpos     = PK_W'(32'(och_d1) % OUT_W);
   assign word_idx = NXT_AW'(32'(pix_d1) * WPP + 32'(och_d1) / OUT_W);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_d1     <= 1'b0;
         first_d1   <= 1'b0;
         last_d1    <= 1'b0;
         flast_d1   <= 1'b0;
         och_d1     <= '0;
         pix_d1     <= '0;
         acc        <= '0;
         th_reg     <= '0;
         pack       <= '0;
         we_r       <= 1'b0;
         last_wr_r  <= 1'b0;
         nxt_addr_r <= '0;
      end else begin
         vld_d1    <= (state == S_RUN);
         first_d1  <= (wrd == '0);
         last_d1   <= w_last;
         flast_d1  <= issue_last;
         och_d1    <= och;
         pix_d1    <= pix;
         we_r      <= 1'b0;
         last_wr_r <= 1'b0;
         if (vld_d1) begin
            acc <= pop_sum;
         end
         if (vld_d1 && first_d1) begin
            th_reg <= th_data;
         end
         if (vld_d1 && last_d1) begin
            pack[bpos] <= bit_val;
            // top bit of an output word: the whole word is in pack next cycle
            if (bpos == PK_W'(OUT_W-1)) begin
               we_r       <= 1'b1;
               nxt_addr_r <= word_idx;
               last_wr_r  <= flast_d1;
            end
         end else if (state == S_DONE) begin
            nxt_addr_r <= '0;
         end
      end
   end

   assign nxt_we   = we_r;
   assign nxt_addr = nxt_addr_r;
   assign nxt_data = pack;

endmodule
`default_nettype wire

// File: tb/tb_bnn_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bnn_layer_engine
//  Purpose  : Self-checking bench for bnn_layer_engine with small sizes.
//             Behavioural SRAM models feed the core; written words are
//             captured and compared with a direct arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bnn_layer_engine;

   localparam int ACT_W    = 8;
   localparam int IN_WORDS = 2;
   localparam int OUT_CH   = 8;
   localparam int OUT_W    = 8;
   localparam int NPIX     = 2;
   localparam int CNT_W    = $clog2(ACT_W*IN_WORDS+1);
   localparam int PRE_AW   = $clog2(NPIX*IN_WORDS);
   localparam int WT_AW    = $clog2(OUT_CH*IN_WORDS);
   localparam int TH_AW    = $clog2(OUT_CH);
   localparam int NXT_AW   = $clog2(NPIX*OUT_CH/OUT_W);
   localparam int WPP      = OUT_CH / OUT_W;
   localparam int NWORDS   = NPIX * WPP;
   localparam int NREADS   = NPIX * OUT_CH * IN_WORDS;

   logic              clk, rst, layer_en;
   logic [1:0]        pre_full, pre_empty, nxt_empty, nxt_full;
   logic              pre_en, pre_bank, wt_en, th_en, nxt_we, nxt_bank, busy;
   logic [PRE_AW-1:0] pre_addr;
   logic [WT_AW-1:0]  wt_addr;
   logic [TH_AW-1:0]  th_addr;
   logic [NXT_AW-1:0] nxt_addr;
   logic [ACT_W-1:0]  pre_data, wt_data;
   logic [CNT_W:0]    th_data;
   logic [OUT_W-1:0]  nxt_data;

   bnn_layer_engine #(
      .ACT_W(ACT_W), .IN_WORDS(IN_WORDS), .OUT_CH(OUT_CH), .OUT_W(OUT_W), .NPIX(NPIX)
   ) dut (
      .clk(clk), .rst(rst), .layer_en(layer_en),
      .pre_full(pre_full), .pre_empty(pre_empty), .pre_en(pre_en), .pre_bank(pre_bank),
      .pre_addr(pre_addr), .pre_data(pre_data),
      .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
      .th_en(th_en), .th_addr(th_addr), .th_data(th_data),
      .nxt_empty(nxt_empty), .nxt_full(nxt_full), .nxt_we(nxt_we), .nxt_bank(nxt_bank),
      .nxt_addr(nxt_addr), .nxt_data(nxt_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memories
   logic [ACT_W-1:0] pre_mem [2][NPIX*IN_WORDS];
   logic [ACT_W-1:0] wt_mem  [OUT_CH*IN_WORDS];
   logic [CNT_W:0]   th_mem  [OUT_CH];
   logic [OUT_W-1:0] nxt_mem [2][NWORDS];

   // synchronous-read SRAMs, one cycle latency
   always @(posedge clk) begin
      if (pre_en) pre_data <= pre_mem[pre_bank][pre_addr];
      if (wt_en)  wt_data  <= wt_mem[wt_addr];
      if (th_en)  th_data  <= th_mem[th_addr];
   end

   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, seq = 0, rd_cnt = 0, wr_cnt = 0, pulses = 0;
   int   last_rd = 0, last_wr = 0, done_cyc = 0, since = 0, gap = -1;
   bit   gap_arm = 0, busy_seen = 0;
   logic tb_ib = 1'b0, tb_ob = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // reference: bit b of word a = threshold(sum of XNOR popcounts)
   function automatic logic [OUT_W-1:0] exp_word(input int bank, input int a);
      logic [OUT_W-1:0] r;
      logic [ACT_W-1:0] x;
      logic [CNT_W:0]   th;
      int p, j, o, pop, thr;
      p = a / WPP;
      j = a % WPP;
      r = '0;
      for (int b = 0; b < OUT_W; b++) begin
         o   = j * OUT_W + b;
         pop = 0;
         for (int w = 0; w < IN_WORDS; w++) begin
            x   = ~(pre_mem[bank][p*IN_WORDS+w] ^ wt_mem[o*IN_WORDS+w]);
            pop = pop + $countones(x);
         end
         th  = th_mem[o];
         thr = int'(th[CNT_W-1:0]);
         r[b] = th[CNT_W] ? (pop < thr) : (pop >= thr);
      end
      return r;
   endfunction

   // one clock: sample at the falling edge, check strobes and pulses
   task automatic tick();
      int w_e, o_e, p_e;
      @(negedge clk);
      cyc++;
      busy_seen = busy_seen | busy;
      if (gap_arm) begin
         since++;
         if (pre_en) begin
            gap     = since;
            gap_arm = 0;
         end
      end
      if (pre_en || wt_en) begin
         w_e = seq % IN_WORDS;
         o_e = (seq / IN_WORDS) % OUT_CH;
         p_e = seq / (IN_WORDS * OUT_CH);
         chk("rd_strobe", {pre_en, wt_en, pre_bank, th_en}, {1'b1, 1'b1, tb_ib, (w_e == 0)});
         chk("pre_addr", 64'(pre_addr), 64'(p_e*IN_WORDS + w_e));
         chk("wt_addr", 64'(wt_addr), 64'(o_e*IN_WORDS + w_e));
         if (w_e == 0) chk("th_addr", 64'(th_addr), 64'(o_e));
         seq++;
         rd_cnt++;
         last_rd = cyc;
      end
      if (nxt_we) begin
         chk("wr_bank", 64'(nxt_bank), 64'(tb_ob));
         nxt_mem[nxt_bank][nxt_addr] = nxt_data;
         wr_cnt++;
         last_wr = cyc;
      end
      if (pre_empty != 2'b00 || nxt_full != 2'b00) begin
         chk("done_pulse", {pre_empty, nxt_full, busy}, {2'(1 << tb_ib), 2'(1 << tb_ob), 1'b0});
         pulses++;
         done_cyc = cyc;
         tb_ib    = ~tb_ib;
         tb_ob    = ~tb_ob;
         seq      = 0;
         gap_arm  = 1;
         since    = 0;
      end
   endtask

   task automatic clear_stats();
      rd_cnt    = 0;
      wr_cnt    = 0;
      busy_seen = 0;
   endtask

   task automatic clear_nxt();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < NWORDS; a++)
            nxt_mem[b][a] = 'x;
   endtask

   task automatic fill_random();
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < NPIX*IN_WORDS; a++)
            pre_mem[b][a] = ACT_W'($urandom);
      for (int a = 0; a < OUT_CH*IN_WORDS; a++) wt_mem[a] = ACT_W'($urandom);
      for (int o = 0; o < OUT_CH; o++)
         th_mem[o] = {1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, ACT_W*IN_WORDS))};
   endtask

   task automatic wait_done(input int budget);
      int p0;
      p0 = pulses;
      for (int i = 0; i < budget && pulses == p0; i++) tick();
      chk("frame_done", 64'(pulses - p0), 64'(1));
   endtask

   task automatic check_frame(input string tag, input logic bi, input logic bo);
      for (int a = 0; a < NWORDS; a++)
         chk(tag, 64'(nxt_mem[bo][a]), 64'(exp_word(int'(bi), a)));
      chk("rd_cnt", 64'(rd_cnt), 64'(NREADS));
      chk("wr_cnt", 64'(wr_cnt), 64'(NWORDS));
      chk("lat_wr", 64'(last_wr - last_rd), 64'(2));
      chk("lat_done", 64'(done_cyc - last_rd), 64'(3));
   endtask

   // run one frame on the current banks and check it
   task automatic run_frame(input string tag);
      logic bi, bo;
      bi = tb_ib;
      bo = tb_ob;
      clear_nxt();
      clear_stats();
      layer_en  = 1'b1;
      pre_full  = 2'(1 << bi);
      nxt_empty = 2'(1 << bo);
      wait_done(300);
      pre_full  = 2'b00;
      nxt_empty = 2'b00;
      check_frame(tag, bi, bo);
      tick();
      chk("busy_after", 64'(busy), 64'(0));
   endtask

   initial begin
      logic bi, bo;
      int   p0;
      rst = 1'b1; layer_en = 1'b0; pre_full = 2'b00; nxt_empty = 2'b00;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_outs", {pre_empty, pre_en, pre_bank, pre_addr, wt_en, wt_addr, th_en, th_addr,
                         nxt_full, nxt_we, nxt_bank, nxt_addr, nxt_data, busy}, 64'(0));

      // 1: all ones, pop=16 vs threshold 16 -> every bit set
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < NPIX*IN_WORDS; a++) pre_mem[b][a] = '1;
      for (int a = 0; a < OUT_CH*IN_WORDS; a++) wt_mem[a] = '1;
      for (int o = 0; o < OUT_CH; o++) th_mem[o] = {1'b0, CNT_W'(16)};
      run_frame("t1_data");
      chk("t1_word0", 64'(nxt_mem[0][0]), 64'hFF);

      // 2: neuron 3 gets zero weights (pop 0) against threshold 9, plain then flipped
      wt_mem[3*IN_WORDS] = '0; wt_mem[3*IN_WORDS+1] = '0;
      th_mem[3] = {1'b0, CNT_W'(9)};
      bo = tb_ob;
      run_frame("t2a_data");
      for (int a = 0; a < NWORDS; a++) chk("t2a_bit3", 64'(nxt_mem[bo][a][3]), 64'(0));
      th_mem[3] = {1'b1, CNT_W'(9)};
      bo = tb_ob;
      run_frame("t2b_data");
      for (int a = 0; a < NWORDS; a++) chk("t2b_bit3", 64'(nxt_mem[bo][a][3]), 64'(1));
      fill_random();
      run_frame("t2c_rand");

      // 3: ping-pong, both banks ready -> back-to-back frames with one idle cycle
      fill_random();
      clear_nxt();
      clear_stats();
      bi = tb_ib; bo = tb_ob;
      chk("t3_start_bank", 64'(bi), 64'(0));
      layer_en = 1'b1; pre_full = 2'b11; nxt_empty = 2'b11;
      wait_done(300);
      check_frame("t3_f0", bi, bo);
      clear_stats();
      gap = -1;
      bi = tb_ib; bo = tb_ob;
      wait_done(300);
      pre_full = 2'b00; nxt_empty = 2'b00;
      check_frame("t3_f1", bi, bo);
      chk("t3_gap", 64'(gap), 64'(2));

      // 4: input ready but output bank not free -> hold idle
      fill_random();
      clear_nxt();
      clear_stats();
      bi = tb_ib; bo = tb_ob;
      pre_full = 2'(1 << bi); nxt_empty = 2'b00;
      repeat (10) tick();
      chk("t4_idle_rd", 64'(rd_cnt + wr_cnt), 64'(0));
      chk("t4_idle_busy", 64'(busy_seen), 64'(0));
      nxt_empty = 2'(1 << bo);
      tick();
      chk("t4_start", 64'(pre_en), 64'(1));
      wait_done(300);
      pre_full = 2'b00; nxt_empty = 2'b00;
      check_frame("t4_data", bi, bo);

      // 5: reset at read cycle 10 aborts the frame
      fill_random();
      clear_stats();
      p0 = pulses;
      pre_full = 2'(1 << tb_ib); nxt_empty = 2'(1 << tb_ob);
      for (int i = 0; i < 300 && rd_cnt < 10; i++) tick();
      chk("t5_reads", 64'(rd_cnt), 64'(10));
      rst = 1'b1; pre_full = 2'b00; nxt_empty = 2'b00;
      tb_ib = 1'b0; tb_ob = 1'b0; seq = 0;
      tick();
      chk("t5_outs", {pre_empty, pre_en, pre_bank, pre_addr, wt_en, wt_addr, th_en, th_addr,
                      nxt_full, nxt_we, nxt_bank, nxt_addr, nxt_data, busy}, 64'(0));
      rst = 1'b0;
      clear_stats();
      repeat (6) tick();
      chk("t5_no_pulse", 64'(pulses - p0), 64'(0));
      chk("t5_quiet", 64'(busy_seen), 64'(0));
      run_frame("t5_restart");

      // 6: layer_en dropped mid-frame -> finish, then stay idle
      fill_random();
      clear_nxt();
      clear_stats();
      bi = tb_ib; bo = tb_ob;
      layer_en = 1'b1; pre_full = 2'b11; nxt_empty = 2'b11;
      for (int i = 0; i < 300 && rd_cnt < 5; i++) tick();
      layer_en = 1'b0;
      wait_done(300);
      check_frame("t6_data", bi, bo);
      clear_stats();
      p0 = pulses;
      repeat (40) tick();
      chk("t6_no_restart", 64'(rd_cnt), 64'(0));
      chk("t6_no_busy", 64'(busy_seen), 64'(0));
      chk("t6_no_pulse", 64'(pulses - p0), 64'(0));
      pre_full = 2'b00; nxt_empty = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
